tff_bank_arbiter: RTL and testbench
===================================

TFF_BANK_ARBITER -- requirements
Module: tff_bank_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, number of T-flip-flop cells in the shared bank.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req0  input  1  requester 0 asks for a toggle operation; held high until gnt0 is seen.
REQ-005 mask0  input  WIDTH  requester 0 toggle mask: bit=1 toggles that cell, bit=0 holds it.
REQ-006 req1  input  1  requester 1 request, same rules as req0.
REQ-007 mask1  input  WIDTH  requester 1 toggle mask.
REQ-008 gnt0  output  1  high for exactly one cycle while requester 0's operation is applied.
REQ-009 gnt1  output  1  same as gnt0, for requester 1.
REQ-010 busy  output  1  high while the FSM is in APPLY.
REQ-011 q  output  WIDTH  registered bank state.
REQ-012 qbar  output  WIDTH  bitwise ~q, combinational.

Function
REQ-013 Each bank cell SHALL behave as a JK flip-flop with j=k=mask bit: hold when 0, invert when 1.
REQ-014 FSM states: IDLE, APPLY; no other states.
REQ-015 IDLE: if req0 or req1 is high at a rising edge, select a winner, latch its mask into an internal register, record the winner, and go to APPLY; otherwise stay in IDLE.
REQ-016 APPLY: assert gnt of the recorded winner and busy; at the closing edge set q <= q ^ latched mask, flip the priority pointer, and return to IDLE.
REQ-017 Arbitration: if exactly one request is high, grant it; if both are high, grant the side named by the priority pointer.
REQ-018 The priority pointer SHALL point away from the last winner (round-robin).
REQ-019 gnt0 and gnt1 SHALL never be high together, and SHALL be low in IDLE.
REQ-020 Latency: 1 cycle from sampled request to gnt; q updates at the edge ending the gnt cycle.
REQ-021 Throughput: at most one operation per 2 cycles.
REQ-022 The mask is captured only at the IDLE->APPLY edge; mask changes during APPLY have no effect.
REQ-023 An all-zero mask SHALL still be granted, with q unchanged.
REQ-024 A request dropped before being sampled in IDLE is ignored, with no grant and no state change.
REQ-025 A request still high in the IDLE cycle after its grant is treated as a new request.

Reset
REQ-026 When reset is high at a rising edge: q=0, FSM=IDLE, gnt0=gnt1=0, busy=0, priority pointer -> requester 0, latched mask=0; qbar therefore all ones.
REQ-027 Reset during APPLY SHALL abort the operation: no toggle applied, pointer not updated.
REQ-028 Reset SHALL override all requests in the same cycle.

Configuration
REQ-029 Macro TFF_BANK_STATUS_EN defined: adds output op_count (16 bits) that increments by 1 at every completed APPLY, wraps 0xFFFF->0, and is cleared by reset.
REQ-030 Macro TFF_BANK_STATUS_EN undefined: no op_count port and no counter logic; all other behaviour is identical.

Verification
REQ-031 Reset, then req0=1, mask0=0x0F -> gnt0 high 1 cycle later for 1 cycle; then q=0x0F, qbar=0xF0.
REQ-032 After reset, req0 and req1 high together with mask0=0x01, mask1=0x80, held until granted -> gnt0 first, gnt1 two cycles later, final q=0x81.
REQ-033 Three back-to-back simultaneous request pairs -> grants alternate 0,1,0,1,0,1; no overlap; busy toggles every cycle.
REQ-034 q=0xFF, req1 with mask1=0x00 -> gnt1 pulses and q stays 0xFF; then mask1=0xFF -> q=0x00.
REQ-035 Reset asserted during APPLY with mask0=0xAA -> q=0x00, no gnt, FSM back in IDLE, pointer at requester 0.
REQ-036 With TFF_BANK_STATUS_EN defined: 5 grants -> op_count=5; preset near 0xFFFF -> wraps to 0; reset -> 0.

Source files
------------

// File: rtl/tff_bank_arbiter.sv
// tff_bank_arbiter: two-requester round-robin arbiter sharing one bank of T cells (JK with j=k=mask bit).
// Optional macro TFF_BANK_STATUS_EN adds op_count, a 16-bit count of completed operations.
//   state | meaning
//   IDLE  | waiting for req0/req1; winner and its mask are captured on leaving
//   APPLY | grant pulse to the winner; bank toggles and pointer flips at the closing edge
module tff_bank_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] mask0,
    input  logic             req1,
    input  logic [WIDTH-1:0] mask1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
`ifdef TFF_BANK_STATUS_EN
    ,
    output logic [15:0]      op_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;     // 1 = requester 1 wins a tie
    logic             win_q, win_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] bank_q, bank_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            win_q   <= 1'b0;
            mask_q  <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            mask_q  <= mask_d;
            bank_q  <= bank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        mask_d  = mask_q;
        bank_d  = bank_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win_d   = req1 & (~req0 | ptr_q);
                    mask_d  = win_d ? mask1 : mask0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                busy    = 1'b1;
                gnt0    = ~win_q;
                gnt1    = win_q;
                bank_d  = bank_q ^ mask_q;
                ptr_d   = ~win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign q    = bank_q;
    assign qbar = ~bank_q;

`ifdef TFF_BANK_STATUS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == APPLY) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign op_count = cnt_q;
`endif

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Self-checking bench for tff_bank_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
// Define TFF_BANK_STATUS_EN to also exercise op_count.
module tb_tff_bank_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] mask0 = '0, mask1 = '0;
    logic         gnt0, gnt1, busy;
    logic [W-1:0] q, qbar;
`ifdef TFF_BANK_STATUS_EN
    logic [15:0]  op_count;
`endif

    int errors = 0;
    int checks = 0;

    // behavioural model: pending operation, bank value, preferred side for ties
    bit           m_busy = 0;
    int           m_win  = 0;
    int           m_pref = 0;
    logic [W-1:0] m_mask = '0;
    logic [W-1:0] m_q    = '0;
    logic [15:0]  m_cnt  = '0;

    always #5 clk = ~clk;

    tff_bank_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .mask0 (mask0),
        .req1  (req1),
        .mask1 (mask1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .q     (q),
        .qbar  (qbar)
`ifdef TFF_BANK_STATUS_EN
        ,
        .op_count (op_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_busy = 0; m_q = '0; m_pref = 0; m_mask = '0; m_cnt = '0;
        end else if (m_busy) begin
            m_q    = m_q ^ m_mask;
            m_pref = 1 - m_win;
            m_busy = 0;
            m_cnt  = m_cnt + 16'd1;
        end else if (req0 || req1) begin
            if (req0 && req1) m_win = m_pref;
            else              m_win = req0 ? 0 : 1;
            m_mask = (m_win == 1) ? mask1 : mask0;
            m_busy = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req0 = 1'b1; req1 = 1'b1; mask0 = 8'hFF; mask1 = 8'hFF;
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl: gnt0/gnt1/busy=%b expected 000", {gnt0, gnt1, busy});
        end
        checks++;
        if (q !== 8'h00 || qbar !== 8'hFF) begin
            errors++; $display("FAIL reset_q: q=%h qbar=%h expected 00/ff", q, qbar);
        end
        req0 = 1'b0; req1 = 1'b0; mask0 = '0; mask1 = '0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req0 = 1'b1; mask0 = 8'h0F;
        tick();
        checks++;
        if ({gnt0, gnt1, busy} !== 3'b101) begin
            errors++; $display("FAIL single_gnt: gnt0/gnt1/busy=%b expected 101", {gnt0, gnt1, busy});
        end
        req0 = 1'b0;
        tick();
        checks++;
        if (gnt0 !== 1'b0 || q !== 8'h0F || qbar !== 8'hF0) begin
            errors++; $display("FAIL single_q: gnt0=%b q=%h qbar=%h expected 0/0f/f0", gnt0, q, qbar);
        end
    endtask

    task automatic test_pair();
        do_reset();
        req0 = 1'b1; req1 = 1'b1; mask0 = 8'h01; mask1 = 8'h80;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++; $display("FAIL pair_first: gnt0/gnt1=%b expected 10", {gnt0, gnt1});
        end
        req0 = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1, busy} !== 3'b000 || q !== 8'h01) begin
            errors++; $display("FAIL pair_gap: ctl=%b q=%h expected 000/01", {gnt0, gnt1, busy}, q);
        end
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++; $display("FAIL pair_second: gnt0/gnt1=%b expected 01", {gnt0, gnt1});
        end
        req1 = 1'b0;
        tick();
        checks++;
        if (q !== 8'h81) begin
            errors++; $display("FAIL pair_q: q=%h expected 81", q);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            mask0 = 8'($urandom); mask1 = 8'($urandom);
            tick();
            checks++;
            if (i % 2 == 0) begin
                if (busy !== 1'b1 || gnt0 !== (k % 2 == 0) || gnt1 !== (k % 2 == 1)) begin
                    errors++; $display("FAIL b2b_grant%0d: busy=%b gnt0=%b gnt1=%b expected side %0d", k, busy, gnt0, gnt1, k % 2);
                end
                k++;
            end else if ({gnt0, gnt1, busy} !== 3'b000 || q !== m_q) begin
                errors++; $display("FAIL b2b_idle%0d: ctl=%b q=%h expected 000/%h", i, {gnt0, gnt1, busy}, q, m_q);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_zero_mask();
        do_reset();
        req1 = 1'b1; mask1 = 8'hFF;
        tick();
        req1 = 1'b0; mask1 = 8'h3C;   // change during APPLY must be ignored
        tick();
        checks++;
        if (q !== 8'hFF) begin
            errors++; $display("FAIL zero_setup: q=%h expected ff", q);
        end
        req1 = 1'b1; mask1 = 8'h00;
        tick();
        checks++;
        if ({gnt0, gnt1, busy} !== 3'b011) begin
            errors++; $display("FAIL zero_gnt: ctl=%b expected 011", {gnt0, gnt1, busy});
        end
        req1 = 1'b0;
        tick();
        checks++;
        if (q !== 8'hFF) begin
            errors++; $display("FAIL zero_hold: q=%h expected ff", q);
        end
        req1 = 1'b1; mask1 = 8'hFF;
        tick();
        req1 = 1'b0;
        tick();
        checks++;
        if (q !== 8'h00) begin
            errors++; $display("FAIL zero_full: q=%h expected 00", q);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        req0 = 1'b1; mask0 = 8'h00;   // req0 wins, pointer moves to requester 1
        tick();
        req0 = 1'b0;
        tick();
        req0 = 1'b1; mask0 = 8'hAA;
        tick();
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++; $display("FAIL abort_gnt: gnt0=%b expected 1", gnt0);
        end
        reset = 1'b1;                  // req0 still high: reset must win
        tick();
        reset = 1'b0; req0 = 1'b0;
        checks++;
        if ({gnt0, gnt1, busy} !== 3'b000 || q !== 8'h00) begin
            errors++; $display("FAIL abort_state: ctl=%b q=%h expected 000/00", {gnt0, gnt1, busy}, q);
        end
        req0 = 1'b1; req1 = 1'b1; mask0 = 8'h01; mask1 = 8'h02;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++; $display("FAIL abort_ptr: gnt0/gnt1=%b expected 10", {gnt0, gnt1});
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            req0  = ($urandom_range(0, 2) != 0);
            req1  = ($urandom_range(0, 2) != 0);
            mask0 = 8'($urandom);
            mask1 = 8'($urandom);
            tick();
            checks++;
            if (gnt0 !== (m_busy && m_win == 0) || gnt1 !== (m_busy && m_win == 1) || busy !== m_busy) begin
                errors++; $display("FAIL rand_ctl%0d: gnt0=%b gnt1=%b busy=%b expected busy=%0d win=%0d", i, gnt0, gnt1, busy, m_busy, m_win);
            end
            checks++;
            if (q !== m_q || qbar !== ~m_q) begin
                errors++; $display("FAIL rand_q%0d: q=%h qbar=%h expected %h", i, q, qbar, m_q);
            end
`ifdef TFF_BANK_STATUS_EN
            checks++;
            if (op_count !== m_cnt) begin
                errors++; $display("FAIL rand_cnt%0d: op_count=%0d expected %0d", i, op_count, m_cnt);
            end
`endif
        end
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
    endtask

`ifdef TFF_BANK_STATUS_EN
    task automatic test_op_count();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req0 = 1'b1; mask0 = 8'($urandom);
            tick();
            req0 = 1'b0;
            tick();
        end
        checks++;
        if (op_count !== 16'd5) begin
            errors++; $display("FAIL cnt_five: op_count=%0d expected 5", op_count);
        end
        do_reset();
        checks++;
        if (op_count !== 16'd0) begin
            errors++; $display("FAIL cnt_reset: op_count=%0d expected 0", op_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_back_to_back();
        test_zero_mask();
        test_reset_abort();
        test_random();
`ifdef TFF_BANK_STATUS_EN
        test_op_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
